trail_access_scheduler: RTL and testbench
=========================================

Name: trail_access_scheduler

Overview:
- Sole owner of the trail manager's write port.
- Arbitrates assignment pushes from N BCP propagation lanes and the decision unit, and sequences conflict-driven backtracks from conflict analysis onto the trail manager's multi-cycle backtrack FSM.
- Tracks the current decision level so requesters never supply levels.
- Guarantees that no push is issued while a backtrack is in flight or during the cycle the trail height settles.

Parameters:
- NUM_LANES, 4, number of propagation requester lanes (1..8).
- MAX_VARS, 256, trail capacity; must match the trail manager instance.
- LVL_W, 16, decision-level width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- lane_valid  in  NUM_LANES  per-lane propagation request
- lane_ready  out  NUM_LANES  per-lane accept
- lane_var  in  NUM_LANES*32  per-lane variable id
- lane_value  in  NUM_LANES  per-lane value
- lane_reason  in  NUM_LANES*16  per-lane reason clause id
- dec_valid  in  1  decision request
- dec_ready  out  1  decision accept
- dec_var  in  32  decision variable
- dec_value  in  1  decision value
- bt_req  in  1  backtrack request (held until bt_ack)
- bt_level  in  LVL_W  backtrack target level
- bt_ack  out  1  1-cycle pulse when backtrack fully complete
- prop_flush  out  1  1-cycle pulse: upstream drops queued propagations
- clear_req  in  1  synchronous full clear
- trail_height  in  16  trail manager height
- tm_push, tm_push_var[32], tm_push_value, tm_push_level[LVL_W], tm_push_is_decision, tm_push_reason[16]  out  trail push bus (registered)
- tm_backtrack_en  out  1  trail backtrack start (1-cycle pulse)
- tm_backtrack_to_level  out  LVL_W  trail backtrack target
- tm_backtrack_done  in  1  trail backtrack completion
- tm_clear_all  out  1  registered copy of clear_req
- cur_level  out  LVL_W  scheduler's current decision level
- overflow  out  1  sticky: push blocked at capacity
- busy  out  1  high in any state other than SERVE

Behaviour:
- Reset is reset, asynchronous, active-high; clock is clk. On reset all outputs are 0, cur_level=0, RR pointer=0, state=SERVE.
- States: SERVE, BT_WAIT, BT_SETTLE.
- SERVE priority per cycle: bt_req > propagation lanes > decision. At most one acceptance per cycle.
- bt_req in SERVE: tm_backtrack_en=1 and tm_backtrack_to_level=bt_level registered next cycle; prop_flush pulses the same next cycle; state goes to BT_WAIT. All readies are 0 in the cycle bt_req wins.
- bt_level >= cur_level: no trail backtrack; bt_ack pulses next cycle and state stays SERVE (no-op).
- BT_WAIT: all readies 0; on tm_backtrack_done go to BT_SETTLE and set cur_level=bt_level (captured value).
- BT_SETTLE: all readies 0 for exactly one cycle; bt_ack pulses; return to SERVE.
- Lanes: round-robin grant starting at the RR pointer; after a grant of lane k, pointer = (k+1) mod NUM_LANES. lane_ready[k]=1 only for the granted lane, combinationally in SERVE.
- Accepted lane: next cycle tm_push=1, level=cur_level, is_decision=0, reason=lane_reason.
- Decision is accepted only when no lane_valid is set and no propagation push is outstanding (BCP quiescent). It pushes level=cur_level+1, is_decision=1, reason=16'hFFFF; cur_level increments in the same registered cycle.
- Push latency: exactly 1 cycle from accept to tm_push; tm_push is never high in BT_WAIT or BT_SETTLE.
- Capacity: the scheduler counts pushes issued but not yet reflected in trail_height (0..1). If trail_height plus in-flight >= MAX_VARS, all readies are 0 and overflow is set (sticky until reset or clear).
- cur_level saturates at 2^LVL_W-1; a decision at saturation is refused (dec_ready=0).
- clear_req: highest priority in any state. Next cycle tm_clear_all=1, cur_level=0, overflow=0, state=SERVE, and any pending push/backtrack is cancelled. bt_ack is not pulsed for a cancelled backtrack.
- Simultaneous bt_req and lane_valid: the backtrack wins and the lane stays unaccepted; because prop_flush pulses, the lane must drop it.
- tm_backtrack_done arriving outside BT_WAIT is ignored.

Optional Feature:
- TRAIL_SCHED_STATS_EN defined: adds outputs stat_pushes[32], stat_decisions[32], stat_backtracks[32] and stat_stall_cycles[32]. Stall cycles are counted as any lane_valid with no lane granted. All counters saturate, reset to 0, and clear on clear_req.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Lane 2 valid var=7 value=1 reason=0x0011 with cur_level=3 -> the next cycle has tm_push=1, var=7, level=3, is_decision=0, reason=0x0011.
- All 4 lanes valid and held for 8 cycles, pointer=0 -> grants 0,1,2,3,0,1,2,3, with exactly one lane_ready high per cycle.
- dec_valid var=5 with lane 1 also valid -> lane 1 is pushed first; the decision is pushed the following cycle at level cur_level+1 with is_decision=1, and cur_level increments.
- cur_level=4, bt_req level=1 -> tm_backtrack_en pulse to 1 and prop_flush pulse; readies stay 0 until tm_backtrack_done plus 1 settle cycle; then bt_ack, cur_level=1, and a lane push resumes at level 1.
- trail_height=255 (MAX_VARS=256), two lanes valid -> one push is accepted, then all readies 0 and overflow=1.
- clear_req asserted during BT_WAIT -> tm_clear_all pulse, cur_level=0, state SERVE, no bt_ack; a later tm_backtrack_done is ignored.

Source files
------------

// File: rtl/trail_access_scheduler.sv
// Trail write-port scheduler: arbitrates lane/decision pushes and sequences backtracks.
// Define TRAIL_SCHED_STATS_EN to add saturating activity counters.
module trail_access_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int MAX_VARS  = 256,
    parameter int LVL_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_LANES-1:0]    lane_valid_i,
    output logic [NUM_LANES-1:0]    lane_ready_o,
    input  logic [NUM_LANES*32-1:0] lane_var_i,
    input  logic [NUM_LANES-1:0]    lane_value_i,
    input  logic [NUM_LANES*16-1:0] lane_reason_i,
    input  logic                    dec_valid_i,
    output logic                    dec_ready_o,
    input  logic [31:0]             dec_var_i,
    input  logic                    dec_value_i,
    input  logic                    bt_req_i,
    input  logic [LVL_W-1:0]        bt_level_i,
    output logic                    bt_ack_o,
    output logic                    prop_flush_o,
    input  logic                    clear_req_i,
    input  logic [15:0]             trail_height_i,
    output logic                    tm_push_o,
    output logic [31:0]             tm_push_var_o,
    output logic                    tm_push_value_o,
    output logic [LVL_W-1:0]        tm_push_level_o,
    output logic                    tm_push_is_decision_o,
    output logic [15:0]             tm_push_reason_o,
    output logic                    tm_backtrack_en_o,
    output logic [LVL_W-1:0]        tm_backtrack_to_level_o,
    input  logic                    tm_backtrack_done_i,
    output logic                    tm_clear_all_o,
    output logic [LVL_W-1:0]        cur_level_o,
    output logic                    overflow_o,
    output logic                    busy_o
`ifdef TRAIL_SCHED_STATS_EN
    ,
    output logic [31:0]             stat_pushes_o,
    output logic [31:0]             stat_decisions_o,
    output logic [31:0]             stat_backtracks_o,
    output logic [31:0]             stat_stall_cycles_o
`endif
);

    // state     | meaning
    // SERVE     | accepting backtrack, lane and decision requests
    // BT_WAIT   | trail manager unwinding; all requesters held off
    // BT_SETTLE | trail height settling for one cycle; bt_ack high
    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        BT_WAIT   = 2'd1,
        BT_SETTLE = 2'd2
    } state_t;

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LVL_W-1:0] LVL_MAX = '1;

    state_t             state_q;
    logic [PTR_W-1:0]   rr_q;
    logic [LVL_W-1:0]   cur_level_q;
    logic [LVL_W-1:0]   bt_target_q;
    logic               overflow_q;
    logic               tm_push_q;
    logic [31:0]        push_var_q;
    logic               push_value_q;
    logic [LVL_W-1:0]   push_level_q;
    logic               push_is_dec_q;
    logic [15:0]        push_reason_q;
    logic               bt_en_q;
    logic               flush_q;
    logic               bt_ack_q;
    logic               clear_all_q;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     cand_sum;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   rr_d;
    logic [31:0]        sel_var;
    logic               sel_value;
    logic [15:0]        sel_reason;
    logic [16:0]        occupancy;
    logic               at_cap;
    logic               bt_win;
    logic               serve_open;
    logic               lane_grant;
    logic               dec_accept;
    logic               ovf_hit;

    // Round-robin search starting at the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand_sum = {1'b0, rr_q} + (PTR_W+1)'(i);
            if (cand_sum >= (PTR_W+1)'(NUM_LANES)) begin
                cand_sum = cand_sum - (PTR_W+1)'(NUM_LANES);
            end
            cand = cand_sum[PTR_W-1:0];
            if (!grant_found && lane_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_var    = '0;
        sel_value  = 1'b0;
        sel_reason = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_var    = lane_var_i[i*32 +: 32];
                sel_value  = lane_value_i[i];
                sel_reason = lane_reason_i[i*16 +: 16];
            end
        end
    end

    assign rr_d = (grant_idx == PTR_W'(NUM_LANES - 1)) ? '0 : grant_idx + PTR_W'(1);

    // A push registered this cycle is not yet counted in trail_height_i.
    assign occupancy = {1'b0, trail_height_i} + {16'b0, tm_push_q};
    assign at_cap    = occupancy >= 17'(MAX_VARS);

    // bt_ack_q masks the requester's still-high bt_req during the ack cycle.
    assign bt_win     = (state_q == SERVE) && !clear_req_i && bt_req_i && !bt_ack_q;
    assign serve_open = (state_q == SERVE) && !clear_req_i && !bt_win && !at_cap;
    assign lane_grant = serve_open && grant_found;
    assign dec_ready_o = serve_open && (lane_valid_i == '0) && (cur_level_q != LVL_MAX);
    assign dec_accept = dec_ready_o && dec_valid_i;
    assign ovf_hit    = (state_q == SERVE) && !clear_req_i && !bt_win && at_cap &&
                        ((lane_valid_i != '0) || dec_valid_i);

    always_comb begin
        lane_ready_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_ready_o[i] = lane_grant && (grant_idx == PTR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SERVE;
            rr_q          <= '0;
            cur_level_q   <= '0;
            bt_target_q   <= '0;
            overflow_q    <= 1'b0;
            tm_push_q     <= 1'b0;
            push_var_q    <= '0;
            push_value_q  <= 1'b0;
            push_level_q  <= '0;
            push_is_dec_q <= 1'b0;
            push_reason_q <= '0;
            bt_en_q       <= 1'b0;
            flush_q       <= 1'b0;
            bt_ack_q      <= 1'b0;
            clear_all_q   <= 1'b0;
        end else begin
            tm_push_q   <= 1'b0;
            bt_en_q     <= 1'b0;
            flush_q     <= 1'b0;
            bt_ack_q    <= 1'b0;
            clear_all_q <= 1'b0;
            if (clear_req_i) begin
                clear_all_q <= 1'b1;
                cur_level_q <= '0;
                overflow_q  <= 1'b0;
                state_q     <= SERVE;
            end else begin
                case (state_q)
                    SERVE: begin
                        if (bt_win) begin
                            if (bt_level_i < cur_level_q) begin
                                bt_en_q     <= 1'b1;
                                flush_q     <= 1'b1;
                                bt_target_q <= bt_level_i;
                                state_q     <= BT_WAIT;
                            end else begin
                                bt_ack_q <= 1'b1;
                            end
                        end else if (lane_grant) begin
                            tm_push_q     <= 1'b1;
                            push_var_q    <= sel_var;
                            push_value_q  <= sel_value;
                            push_level_q  <= cur_level_q;
                            push_is_dec_q <= 1'b0;
                            push_reason_q <= sel_reason;
                            rr_q          <= rr_d;
                        end else if (dec_accept) begin
                            tm_push_q     <= 1'b1;
                            push_var_q    <= dec_var_i;
                            push_value_q  <= dec_value_i;
                            push_level_q  <= cur_level_q + 1'b1;
                            push_is_dec_q <= 1'b1;
                            push_reason_q <= 16'hFFFF;
                            cur_level_q   <= cur_level_q + 1'b1;
                        end
                        if (ovf_hit) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    BT_WAIT: begin
                        if (tm_backtrack_done_i) begin
                            cur_level_q <= bt_target_q;
                            bt_ack_q    <= 1'b1;
                            state_q     <= BT_SETTLE;
                        end
                    end
                    BT_SETTLE: begin
                        state_q <= SERVE;
                    end
                    default: begin
                        state_q <= SERVE;
                    end
                endcase
            end
        end
    end

    assign tm_push_o               = tm_push_q;
    assign tm_push_var_o           = push_var_q;
    assign tm_push_value_o         = push_value_q;
    assign tm_push_level_o         = push_level_q;
    assign tm_push_is_decision_o   = push_is_dec_q;
    assign tm_push_reason_o        = push_reason_q;
    assign tm_backtrack_en_o       = bt_en_q;
    assign tm_backtrack_to_level_o = bt_target_q;
    assign prop_flush_o            = flush_q;
    assign bt_ack_o                = bt_ack_q;
    assign tm_clear_all_o          = clear_all_q;
    assign cur_level_o             = cur_level_q;
    assign overflow_o              = overflow_q;
    assign busy_o                  = (state_q != SERVE);

`ifdef TRAIL_SCHED_STATS_EN
    logic [31:0] stat_pushes_q;
    logic [31:0] stat_decisions_q;
    logic [31:0] stat_backtracks_q;
    logic [31:0] stat_stall_q;
    logic        real_bt;
    logic        stall;

    assign real_bt = bt_win && (bt_level_i < cur_level_q);
    assign stall   = (lane_valid_i != '0) && !lane_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pushes_q     <= '0;
            stat_decisions_q  <= '0;
            stat_backtracks_q <= '0;
            stat_stall_q      <= '0;
        end else if (clear_req_i) begin
            stat_pushes_q     <= '0;
            stat_decisions_q  <= '0;
            stat_backtracks_q <= '0;
            stat_stall_q      <= '0;
        end else begin
            if ((lane_grant || dec_accept) && (stat_pushes_q != '1)) begin
                stat_pushes_q <= stat_pushes_q + 32'd1;
            end
            if (dec_accept && (stat_decisions_q != '1)) begin
                stat_decisions_q <= stat_decisions_q + 32'd1;
            end
            if (real_bt && (stat_backtracks_q != '1)) begin
                stat_backtracks_q <= stat_backtracks_q + 32'd1;
            end
            if (stall && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_pushes_o       = stat_pushes_q;
    assign stat_decisions_o    = stat_decisions_q;
    assign stat_backtracks_o   = stat_backtracks_q;
    assign stat_stall_cycles_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_trail_access_scheduler.sv
// Bench for trail_access_scheduler: behavioural model with per-cycle compare plus directed literals.
module tb_trail_access_scheduler;
    localparam int N  = 4;
    localparam int MV = 256;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    lane_valid;
    logic [N-1:0]    lane_ready;
    logic [N*32-1:0] lane_var;
    logic [N-1:0]    lane_value;
    logic [N*16-1:0] lane_reason;
    logic            dec_valid, dec_ready, dec_value;
    logic [31:0]     dec_var;
    logic            bt_req, bt_ack, prop_flush, clear_req;
    logic [LW-1:0]   bt_level;
    logic [15:0]     th;
    logic            tm_push, tm_push_value, tm_push_is_decision;
    logic [31:0]     tm_push_var;
    logic [LW-1:0]   tm_push_level, tm_bt_to, cur_level;
    logic [15:0]     tm_push_reason;
    logic            tm_bt_en, tm_bt_done, tm_clear_all, overflow, busy;
`ifdef TRAIL_SCHED_STATS_EN
    logic [31:0]     s_push, s_dec, s_bt, s_stall;
`endif

    always #5 clk = ~clk;

    trail_access_scheduler #(.NUM_LANES(N), .MAX_VARS(MV), .LVL_W(LW)) dut (
        .clk(clk), .reset(reset),
        .lane_valid_i(lane_valid), .lane_ready_o(lane_ready), .lane_var_i(lane_var),
        .lane_value_i(lane_value), .lane_reason_i(lane_reason),
        .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_var_i(dec_var), .dec_value_i(dec_value),
        .bt_req_i(bt_req), .bt_level_i(bt_level), .bt_ack_o(bt_ack), .prop_flush_o(prop_flush),
        .clear_req_i(clear_req), .trail_height_i(th),
        .tm_push_o(tm_push), .tm_push_var_o(tm_push_var), .tm_push_value_o(tm_push_value),
        .tm_push_level_o(tm_push_level), .tm_push_is_decision_o(tm_push_is_decision),
        .tm_push_reason_o(tm_push_reason),
        .tm_backtrack_en_o(tm_bt_en), .tm_backtrack_to_level_o(tm_bt_to),
        .tm_backtrack_done_i(tm_bt_done), .tm_clear_all_o(tm_clear_all),
        .cur_level_o(cur_level), .overflow_o(overflow), .busy_o(busy)
`ifdef TRAIL_SCHED_STATS_EN
        , .stat_pushes_o(s_push), .stat_decisions_o(s_dec),
        .stat_backtracks_o(s_bt), .stat_stall_cycles_o(s_stall)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state: phase 0 = serving, 1 = waiting on trail unwind, 2 = settle cycle.
    int          m_phase = 0;
    int          m_rr = 0;
    logic [15:0] m_level = '0, m_target = '0;
    bit          m_ovf = 0, m_inflight = 0, m_ack_prev = 0;
    bit          pend = 0;
    logic [N-1:0] last_lr;

    // Expected registered outputs for the current cycle.
    bit          e_push = 0, e_value = 0, e_isdec = 0, e_bt_en = 0, e_flush = 0, e_ack = 0, e_clear = 0;
    logic [31:0] e_var = '0;
    logic [15:0] e_level = '0, e_reason = '0, e_bt_to = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tm_push", tm_push, e_push);
            if (e_push) begin
                chk("push_var", tm_push_var, e_var);
                chk("push_value", tm_push_value, e_value);
                chk("push_level", tm_push_level, e_level);
                chk("push_is_dec", tm_push_is_decision, e_isdec);
                chk("push_reason", tm_push_reason, e_reason);
            end
            chk("bt_en", tm_bt_en, e_bt_en);
            if (e_bt_en) chk("bt_to", tm_bt_to, e_bt_to);
            chk("prop_flush", prop_flush, e_flush);
            chk("bt_ack", bt_ack, e_ack);
            chk("clear_all", tm_clear_all, e_clear);
            chk("cur_level", cur_level, m_level);
            chk("overflow", overflow, m_ovf);
            chk("busy", busy, m_phase != 0);
        end
    end

    // One clock cycle: check readies, advance the model, let the trail manager model absorb pushes.
    task automatic cyc();
        bit bt_win, cap, open, edr;
        int g;
        logic [N-1:0] elr;
        #1;
        bt_win = !clear_req && (m_phase == 0) && bt_req && !m_ack_prev;
        cap    = (int'(th) + (m_inflight ? 1 : 0)) >= MV;
        open   = !clear_req && (m_phase == 0) && !bt_win && !cap;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (g < 0 && lane_valid[j]) g = j;
        end
        elr = '0;
        if (open && g >= 0) elr[g] = 1'b1;
        edr = open && (lane_valid == '0) && (m_level != 16'hFFFF);
        chk("lane_ready", lane_ready, elr);
        chk("dec_ready", dec_ready, edr);
        last_lr = lane_ready;

        e_push = 0; e_bt_en = 0; e_flush = 0; e_ack = 0; e_clear = 0;
        if (clear_req) begin
            e_clear = 1; m_level = 0; m_ovf = 0; m_phase = 0;
        end else if (m_phase == 0) begin
            if (bt_win) begin
                if (bt_level < m_level) begin
                    e_bt_en = 1; e_flush = 1; e_bt_to = bt_level; m_target = bt_level; m_phase = 1;
                end else begin
                    e_ack = 1;
                end
            end else if (open && g >= 0) begin
                e_push = 1; e_var = lane_var[g*32 +: 32]; e_value = lane_value[g];
                e_level = m_level; e_isdec = 0; e_reason = lane_reason[g*16 +: 16];
                m_rr = (g + 1) % N;
            end else if (edr && dec_valid) begin
                e_push = 1; e_var = dec_var; e_value = dec_value;
                e_level = m_level + 16'd1; e_isdec = 1; e_reason = 16'hFFFF;
                m_level = m_level + 16'd1;
            end
            if (!bt_win && cap && ((lane_valid != '0) || dec_valid)) m_ovf = 1;
        end else if (m_phase == 1) begin
            if (tm_bt_done) begin
                m_level = m_target; m_phase = 2; e_ack = 1;
            end
        end else begin
            m_phase = 0;
        end
        m_inflight = e_push;
        m_ack_prev = e_ack;

        @(posedge clk);
        @(negedge clk);
        #1;
        if (tm_clear_all) begin
            th = 0; pend = 0;
        end else begin
            if (pend) th = th + 16'd1;
            pend = tm_push;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] grants [8];
    logic [N-1:0] exp_g;

    initial begin
        reset = 1; lane_valid = '0; lane_var = '0; lane_value = '0; lane_reason = '0;
        dec_valid = 0; dec_var = '0; dec_value = 0; bt_req = 0; bt_level = '0;
        clear_req = 0; th = '0; tm_bt_done = 0;
        repeat (2) @(negedge clk);
        chk("rst_push", tm_push, 0);
        chk("rst_level", cur_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_bt_ack", bt_ack, 0);
        chk("rst_lane_ready", lane_ready, 0);
        #1 reset = 0;
        chk_en = 1;

        // Raise the level to 3 with three decisions.
        for (int i = 0; i < 3; i++) begin
            dec_valid = 1; dec_var = 32'd100 + i; dec_value = i[0];
            cyc();
        end
        dec_valid = 0;
        chk("lvl3_dut", cur_level, 3);
        chk("lvl3_model", m_level, 3);

        // Lane 2 push at level 3.
        lane_var = {32'd13, 32'd7, 32'd11, 32'd10};
        lane_value = 4'b0100;
        lane_reason = {16'h0033, 16'h0011, 16'h0022, 16'h0044};
        lane_valid = 4'b0100;
        cyc();
        lane_valid = '0;
        chk("l2_push", tm_push, 1);
        chk("l2_var", tm_push_var, 7);
        chk("l2_level", tm_push_level, 3);
        chk("l2_isdec", tm_push_is_decision, 0);
        chk("l2_reason", tm_push_reason, 16'h0011);

        // Lane 3 alone wraps the pointer back to 0, then all four lanes held for 8 cycles.
        lane_valid = 4'b1000;
        cyc();
        lane_var = {32'd13, 32'd12, 32'd11, 32'd10};
        lane_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            cyc();
            grants[c] = last_lr;
        end
        lane_valid = '0;
        for (int c = 0; c < 8; c++) begin
            exp_g = 4'b0001 << (c % 4);
            chk("rr_seq", grants[c], exp_g);
        end

        // Decision waits behind lane 1.
        lane_valid = 4'b0010; dec_valid = 1; dec_var = 32'd5; dec_value = 0;
        cyc();
        lane_valid = '0;
        chk("dl_lane_var", tm_push_var, 11);
        chk("dl_lane_isdec", tm_push_is_decision, 0);
        cyc();
        dec_valid = 0;
        chk("dl_dec_var", tm_push_var, 5);
        chk("dl_dec_level", tm_push_level, 4);
        chk("dl_dec_isdec", tm_push_is_decision, 1);
        chk("dl_dec_reason", tm_push_reason, 16'hFFFF);
        chk("dl_cur_level", cur_level, 4);

        // Backtrack 4 -> 1 with a colliding lane request.
        bt_req = 1; bt_level = 16'd1; lane_valid = 4'b0001;
        cyc();
        chk("bt_en_pulse", tm_bt_en, 1);
        chk("bt_to_level", tm_bt_to, 1);
        chk("bt_flush", prop_flush, 1);
        repeat (3) cyc();
        tm_bt_done = 1;
        cyc();
        tm_bt_done = 0;
        chk("bt_ack_pulse", bt_ack, 1);
        chk("bt_new_level", cur_level, 1);
        bt_req = 0;
        cyc();
        cyc();
        lane_valid = '0;
        chk("bt_resume_push", tm_push, 1);
        chk("bt_resume_level", tm_push_level, 1);

        // No-op backtrack; bt_req held through the ack cycle.
        bt_req = 1; bt_level = 16'd5;
        cyc();
        chk("noop_ack", bt_ack, 1);
        chk("noop_busy", busy, 0);
        cyc();
        bt_req = 0;
        chk("noop_no_reack", bt_ack, 0);
        cyc();

        // Capacity: one push from height 255, then blocked.
        th = 16'd255; pend = 0;
        lane_valid = 4'b0011;
        repeat (3) cyc();
        chk("cap_ovf", overflow, 1);
        chk("cap_ready", last_lr, 0);
        lane_valid = '0;
        clear_req = 1;
        cyc();
        clear_req = 0;
        chk("clr_pulse", tm_clear_all, 1);
        chk("clr_ovf", overflow, 0);
        chk("clr_level", cur_level, 0);

        // Clear during BT_WAIT cancels the backtrack; late done is ignored.
        dec_valid = 1; dec_var = 32'd9;
        repeat (2) cyc();
        dec_valid = 0;
        bt_req = 1; bt_level = 16'd0;
        cyc();
        chk("cbt_busy", busy, 1);
        repeat (2) cyc();
        clear_req = 1; bt_req = 0;
        cyc();
        clear_req = 0;
        chk("cbt_clear", tm_clear_all, 1);
        chk("cbt_level", cur_level, 0);
        chk("cbt_busy_off", busy, 0);
        chk("cbt_no_ack", bt_ack, 0);
        tm_bt_done = 1;
        cyc();
        tm_bt_done = 0;
        chk("late_done_busy", busy, 0);
        chk("late_done_ack", bt_ack, 0);

        // Mixed lane/decision traffic.
        for (int i = 0; i < 12; i++) begin
            logic [4:0] pat;
            logic [59:0] tbl;
            tbl = 60'hA_1_7_4_1_9_0_F_3_6_C_1_8_2_5;
            pat = tbl[i*5 +: 5];
            lane_valid = pat[3:0]; dec_valid = pat[4];
            lane_var = {$urandom, $urandom, $urandom, $urandom};
            lane_reason = {16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3)};
            dec_var = 32'h1000 + i;
            cyc();
        end
        lane_valid = '0; dec_valid = 0;
        repeat (2) cyc();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
